// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the AESL deadlock monitor consumers.
// Channel fields are packed 3 bits per channel, channel 0 in the low bits.
package aesl_deadlock_pkg;

    localparam int FIELD_W  = 3;
    localparam int INFO_MAX = 96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WATCH,
        ST_DETECTED,
        ST_REPORT,
        ST_DONE
    } dl_state_e;

    // Callers pass the info bus cast up to INFO_MAX bits.
    function automatic logic [FIELD_W-1:0] field_of(input logic [INFO_MAX-1:0] info, input int c);
        return info[FIELD_W*c +: FIELD_W];
    endfunction

endpackage

// File: rtl/aesl_deadlock_report_unit.sv
// Deadlock verdict and per-channel report beats for one monitored instance.
//   state    | meaning
//   IDLE     | no block seen, persistence count at 0
//   WATCH    | block asserted, counting samples with an unchanged blocked set
//   DETECTED | verdict latched this cycle, scan index reset
//   REPORT   | walking channels, one beat per nonzero field
//   DONE     | verdict held until clear
module aesl_deadlock_report_unit
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_CHAN  = 3,
    parameter int INFO_W    = 3*NUM_CHAN,
    parameter int THRESHOLD = 1000,
    parameter int CNT_W     = $clog2(THRESHOLD+1),
    parameter int CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               block,
    input  logic [INFO_W-1:0]  axis_block_info,
    input  logic               clear,
    input  logic               report_ready,
    output logic               deadlock,
    output logic [INFO_W-1:0]  deadlock_info,
    output logic               report_valid,
    output logic [CHAN_W-1:0]  report_chan,
    output logic [FIELD_W-1:0] report_field,
    output logic               report_last,
    output logic [CNT_W-1:0]   watch_cnt
);

    dl_state_e            state, state_nxt;
    logic [INFO_W-1:0]    snapshot, snap_nxt, dli_nxt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [CHAN_W-1:0]    scan_idx, scan_nxt, rc_nxt;
    logic [FIELD_W-1:0]   rf_nxt, scan_field;
    logic                 dl_nxt, rv_nxt, rl_nxt;
    logic [INFO_MAX-1:0]  info_pad;
    logic [NUM_CHAN-1:0]  nz_mask;
    logic                 scan_last, info_same, at_limit, handshake, load_ok;

    assign info_pad   = INFO_MAX'(deadlock_info);
    assign scan_field = (32'(scan_idx) < NUM_CHAN) ? field_of(info_pad, int'(scan_idx)) : '0;
    assign scan_last  = ((nz_mask >> scan_idx) >> 1) == '0;
    assign info_same  = (axis_block_info == snapshot);
    assign at_limit   = (watch_cnt == CNT_W'(THRESHOLD-1));
    assign handshake  = report_valid & report_ready;
    assign load_ok    = !report_valid || handshake;

    always_comb begin
        nz_mask = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            nz_mask[c] = |field_of(info_pad, c);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (block) state_nxt = ST_WATCH;
                ST_WATCH: begin
                    if (!block)                     state_nxt = ST_IDLE;
                    else if (info_same && at_limit) state_nxt = ST_DETECTED;
                end
                ST_DETECTED: state_nxt = (deadlock_info == '0) ? ST_DONE : ST_REPORT;
                ST_REPORT:   if (handshake && report_last) state_nxt = ST_DONE;
                ST_DONE:     state_nxt = ST_DONE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt  = watch_cnt;
        snap_nxt = snapshot;
        dl_nxt   = deadlock;
        dli_nxt  = deadlock_info;
        scan_nxt = scan_idx;
        rv_nxt   = report_valid;
        rc_nxt   = report_chan;
        rf_nxt   = report_field;
        rl_nxt   = report_last;
        if (clear) begin
            cnt_nxt  = '0;
            snap_nxt = '0;
            dl_nxt   = 1'b0;
            dli_nxt  = '0;
            scan_nxt = '0;
            rv_nxt   = 1'b0;
            rc_nxt   = '0;
            rf_nxt   = '0;
            rl_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = block ? CNT_W'(1) : '0;
                    if (block) snap_nxt = axis_block_info;
                end
                ST_WATCH: begin
                    if (!block) begin
                        cnt_nxt = '0;
                    end else if (!info_same) begin
                        // A moving blocked set is progress; restart the count.
                        cnt_nxt  = CNT_W'(1);
                        snap_nxt = axis_block_info;
                    end else if (at_limit) begin
                        cnt_nxt = CNT_W'(THRESHOLD);
                        dl_nxt  = 1'b1;
                        dli_nxt = snapshot;
                    end else begin
                        cnt_nxt = watch_cnt + CNT_W'(1);
                    end
                end
                ST_DETECTED: scan_nxt = '0;
                ST_REPORT: begin
                    if (handshake && report_last) begin
                        rv_nxt = 1'b0;
                        rc_nxt = '0;
                        rf_nxt = '0;
                        rl_nxt = 1'b0;
                    end else if (load_ok) begin
                        // Load the next nonzero channel on the handshake edge itself.
                        rv_nxt   = (scan_field != '0);
                        rc_nxt   = (scan_field != '0) ? scan_idx : '0;
                        rf_nxt   = scan_field;
                        rl_nxt   = (scan_field != '0) && scan_last;
                        scan_nxt = scan_idx + CHAN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            watch_cnt     <= '0;
            snapshot      <= '0;
            deadlock      <= 1'b0;
            deadlock_info <= '0;
            scan_idx      <= '0;
            report_valid  <= 1'b0;
            report_chan   <= '0;
            report_field  <= '0;
            report_last   <= 1'b0;
        end else begin
            watch_cnt     <= cnt_nxt;
            snapshot      <= snap_nxt;
            deadlock      <= dl_nxt;
            deadlock_info <= dli_nxt;
            scan_idx      <= scan_nxt;
            report_valid  <= rv_nxt;
            report_chan   <= rc_nxt;
            report_field  <= rf_nxt;
            report_last   <= rl_nxt;
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_report_unit.sv
// Self-checking bench for aesl_deadlock_report_unit with THRESHOLD=8, three channels.
module tb_aesl_deadlock_report_unit;

    localparam int TH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       block = 1'b0;
    logic       clear = 1'b0;
    logic       report_ready = 1'b0;
    logic [8:0] axis_block_info = '0;
    logic       deadlock;
    logic [8:0] deadlock_info;
    logic       report_valid;
    logic [1:0] report_chan;
    logic [2:0] report_field;
    logic       report_last;
    logic [3:0] watch_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic [8:0] info;
        int         stall;
        logic [8:0] pre_info;
        int         pre_len;
        int         n;
        logic [5:0] chs;
        logic [8:0] flds;
    } vec_t;

    vec_t vecs[6];

    aesl_deadlock_report_unit #(.NUM_CHAN(3), .THRESHOLD(TH)) dut (
        .clock(clock), .reset(reset), .block(block), .axis_block_info(axis_block_info),
        .clear(clear), .report_ready(report_ready), .deadlock(deadlock),
        .deadlock_info(deadlock_info), .report_valid(report_valid), .report_chan(report_chan),
        .report_field(report_field), .report_last(report_last), .watch_cnt(watch_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: the beats are simply the nonzero 3-bit fields in ascending channel order.
    function automatic int model_beats(input logic [8:0] info, output logic [5:0] chs, output logic [8:0] flds);
        int n;
        logic [2:0] f;
        n = 0;
        chs = '0;
        flds = '0;
        for (int c = 0; c < 3; c++) begin
            f = 3'(info >> (3*c));
            if (f != 3'd0) begin
                chs[2*n +: 2]  = 2'(c);
                flds[3*n +: 3] = f;
                n++;
            end
        end
        return n;
    endfunction

    task automatic check_cleared(input string tag);
        check({tag, "_deadlock"}, 32'(deadlock), 0);
        check({tag, "_info"}, 32'(deadlock_info), 0);
        check({tag, "_cnt"}, 32'(watch_cnt), 0);
        check({tag, "_valid"}, 32'(report_valid), 0);
        check({tag, "_chan"}, 32'(report_chan), 0);
        check({tag, "_field"}, 32'(report_field), 0);
        check({tag, "_last"}, 32'(report_last), 0);
    endtask

    task automatic run_report(input logic [8:0] info, input int stall, input logic [8:0] pre_info,
                              input int pre_len, input int exp_n, input logic [5:0] exp_ch,
                              input logic [8:0] exp_fld);
        int cyc, beat, stall_left, exp_at;
        bit seen, acc;
        logic [1:0] hold_c;
        logic [2:0] hold_f;
        logic       hold_l;
        block = 1'b1;
        report_ready = 1'b0;
        axis_block_info = pre_info;
        for (int k = 1; k <= pre_len; k++) begin
            step();
            check("pre_cnt", 32'(watch_cnt), 32'(k));
            check("pre_deadlock", 32'(deadlock), 0);
        end
        axis_block_info = info;
        for (int k = 1; k <= TH; k++) begin
            step();
            check("watch_cnt", 32'(watch_cnt), 32'(k));
            check("deadlock_rise", 32'(deadlock), (k == TH) ? 1 : 0);
        end
        check("deadlock_info", 32'(deadlock_info), 32'(info));
        cyc = 0; beat = 0; seen = 0; acc = 0; stall_left = stall;
        exp_at = 2 + int'(exp_ch[1:0]);
        hold_c = '0; hold_f = '0; hold_l = 1'b0;
        while (beat < exp_n && cyc < 60) begin
            if (report_valid) begin
                if (!seen) begin
                    seen = 1;
                    check("beat_time", 32'(cyc), 32'(exp_at));
                    check("beat_chan", 32'(report_chan), 32'(exp_ch[2*beat +: 2]));
                    check("beat_field", 32'(report_field), 32'(exp_fld[3*beat +: 3]));
                    check("beat_last", 32'(report_last), (beat == exp_n-1) ? 1 : 0);
                    hold_c = report_chan; hold_f = report_field; hold_l = report_last;
                end else begin
                    check("hold_chan", 32'(report_chan), 32'(hold_c));
                    check("hold_field", 32'(report_field), 32'(hold_f));
                    check("hold_last", 32'(report_last), 32'(hold_l));
                end
                if (stall_left == 0) begin
                    report_ready = 1'b1;
                    acc = 1;
                end else begin
                    report_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                report_ready = 1'b0;
            end
            block = 1'($urandom);
            axis_block_info = 9'($urandom);
            step();
            cyc++;
            if (acc) begin
                acc = 0; seen = 0; beat++; stall_left = stall;
                if (beat < exp_n)
                    exp_at = cyc + int'(exp_ch[2*beat +: 2]) - int'(exp_ch[2*(beat-1) +: 2]) - 1;
            end
        end
        if (beat < exp_n) check("beat_timeout", 32'(beat), 32'(exp_n));
        report_ready = 1'b0;
        block = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("done_valid", 32'(report_valid), 0);
            check("done_deadlock", 32'(deadlock), 1);
            check("done_info", 32'(deadlock_info), 32'(info));
            check("cnt_bound", 32'(watch_cnt <= 4'(TH)), 1);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_cleared("clear_done");
    endtask

    task automatic run_drop(input logic [8:0] info, input int len);
        block = 1'b1;
        axis_block_info = info;
        for (int k = 1; k <= len; k++) begin
            step();
            check("drop_cnt", 32'(watch_cnt), 32'(k));
            check("drop_deadlock", 32'(deadlock), 0);
        end
        block = 1'b0;
        step();
        check("drop_cnt_zero", 32'(watch_cnt), 0);
        check("drop_no_deadlock", 32'(deadlock), 0);
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        block = 1'b1;
        axis_block_info = 9'h0EE;
        report_ready = 1'b0;
        for (int k = 0; k < TH; k++) step();
        budget = 0;
        while (!report_valid && budget < 10) begin
            step();
            budget++;
        end
        check({tag, "_valid_seen"}, 32'(report_valid), 1);
    endtask

    initial begin
        logic [5:0] chs;
        logic [8:0] flds;
        logic [8:0] rinfo;
        int n;

        vecs[0] = '{name:"single",   info:9'h0C0, stall:0, pre_info:9'h000, pre_len:0, n:1, chs:6'h02, flds:9'h003};
        vecs[1] = '{name:"restart",  info:9'h02E, stall:0, pre_info:9'h006, pre_len:5, n:2, chs:6'h04, flds:9'h02E};
        vecs[2] = '{name:"backpres", info:9'h0EE, stall:3, pre_info:9'h000, pre_len:0, n:3, chs:6'h24, flds:9'h0EE};
        vecs[3] = '{name:"skip_mid", info:9'h0C6, stall:1, pre_info:9'h000, pre_len:0, n:2, chs:6'h08, flds:9'h01E};
        vecs[4] = '{name:"all_zero", info:9'h000, stall:0, pre_info:9'h000, pre_len:0, n:0, chs:6'h00, flds:9'h000};
        vecs[5] = '{name:"ch1_only", info:9'h028, stall:2, pre_info:9'h000, pre_len:0, n:1, chs:6'h01, flds:9'h005};

        // Reset held with random inputs
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            block = 1'($urandom);
            clear = 1'($urandom);
            report_ready = 1'($urandom);
            axis_block_info = 9'($urandom);
            step();
            check_cleared("reset");
        end
        block = 1'b0; clear = 1'b0; report_ready = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_cnt", 32'(watch_cnt), 0);
        end

        run_drop(9'h0C0, 7);

        for (int i = 0; i < 6; i++)
            run_report(vecs[i].info, vecs[i].stall, vecs[i].pre_info, vecs[i].pre_len,
                       vecs[i].n, vecs[i].chs, vecs[i].flds);

        // Clear wins over a pending handshake
        wait_valid("clrprio");
        report_ready = 1'b1;
        clear = 1'b1;
        block = 1'b0;
        step();
        clear = 1'b0;
        report_ready = 1'b0;
        check_cleared("clrprio");

        // Asynchronous reset in the middle of the report
        wait_valid("midrst");
        reset = 1'b0;
        #1;
        check("midrst_drop", 32'(report_valid), 0);
        check("midrst_deadlock", 32'(deadlock), 0);
        block = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("midrst_no_beat", 32'(report_valid), 0);
            check("midrst_no_dl", 32'(deadlock), 0);
        end

        // Randomized scenarios against the channel-list model
        for (int it = 0; it < 16; it++) begin
            rinfo = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_drop(rinfo, int'($urandom_range(1, TH-1)));
            end else begin
                n = model_beats(rinfo, chs, flds);
                if ($urandom_range(0, 1) == 1)
                    run_report(rinfo, int'($urandom_range(0, 2)), rinfo ^ 9'($urandom_range(1, 511)),
                               int'($urandom_range(1, 6)), n, chs, flds);
                else
                    run_report(rinfo, int'($urandom_range(0, 2)), 9'h000, 0, n, chs, flds);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
